// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequencing controller for the gshare 2-bit counter array.
//
// After reset the controller sweeps every counter to weakly-not-taken (2'b01),
// one entry per cycle. It then drains resolved-branch updates from a small
// FIFO. Each update is a two-cycle read-modify-write: IDLE reads the counter
// on the array's second read port, and WRITE writes the saturated result.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   upd_valid_i/idx/taken  resolved-branch update from WB (valid/ready handshake)
//   upd_ready_o            queue can accept an update this cycle
//   flush_i                discard queued updates (an in-flight write still commits)
//   arr_rd_idx_o/data_i    counter-array read port 2 (combinational read data)
//   arr_wr_en/idx/data_o   counter-array write port
//   init_busy_o            initialisation sweep in progress
//   q_empty_o              queue empty and no read-modify-write in flight
//
// Optional build macro BP_UPD_STATS_EN adds upd_count_o (WRITE-state writes,
// saturating 16 bits) and drop_count_o (entries discarded by flush, saturating
// 8 bits).
module bp_update_ctrl #(
  parameter int unsigned INDEX_BITS  = 5,
  parameter int unsigned QUEUE_DEPTH = 4  // power of two, at least 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  upd_valid_i,
  input  logic [INDEX_BITS-1:0] upd_idx_i,
  input  logic                  upd_taken_i,
  output logic                  upd_ready_o,
  input  logic                  flush_i,
  output logic [INDEX_BITS-1:0] arr_rd_idx_o,
  input  logic [1:0]            arr_rd_data_i,
  output logic                  arr_wr_en_o,
  output logic [INDEX_BITS-1:0] arr_wr_idx_o,
  output logic [1:0]            arr_wr_data_o,
  output logic                  init_busy_o,
  output logic                  q_empty_o
`ifdef BP_UPD_STATS_EN
  ,
  output logic [15:0]           upd_count_o,
  output logic [7:0]            drop_count_o
`endif
);

  localparam int unsigned AddrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [1:0] {StInit, StIdle, StWrite} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [INDEX_BITS-1:0] rmw_idx_q, rmw_idx_d;
  logic [1:0]            rmw_data_q, rmw_data_d;
  logic                  rmw_taken_q, rmw_taken_d;

  logic [INDEX_BITS-1:0] q_idx_q   [QUEUE_DEPTH];
  logic                  q_taken_q [QUEUE_DEPTH];

  logic [AddrW-1:0]      wr_addr, rd_addr;
  logic                  empty, full, push, pop;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_taken;

  logic                  wr_en_raw;
  logic [INDEX_BITS-1:0] wr_idx_raw;
  logic [1:0]            wr_data_raw;

  function automatic logic [1:0] sat_update(input logic [1:0] v, input logic taken);
    if (taken) return (v == 2'b11) ? v : v + 2'd1;
    return (v == 2'b00) ? v : v - 2'd1;
  endfunction

  // Queue bookkeeping: the extra pointer MSB distinguishes full from empty.
  assign wr_addr    = wr_ptr_q[AddrW-1:0];
  assign rd_addr    = rd_ptr_q[AddrW-1:0];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_addr == rd_addr);
  assign head_idx   = q_idx_q[rd_addr];
  assign head_taken = q_taken_q[rd_addr];
  assign push       = upd_valid_i & ~full & ~flush_i;
  assign pop        = (state_q == StIdle) & ~empty & ~flush_i;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    rmw_idx_d   = rmw_idx_q;
    rmw_data_d  = rmw_data_q;
    rmw_taken_d = rmw_taken_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + INDEX_BITS'(1);
        if (sweep_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (pop) begin
          rmw_idx_d   = head_idx;
          rmw_data_d  = arr_rd_data_i;
          rmw_taken_d = head_taken;
          state_d     = StWrite;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Flush empties the queue and swallows any same-cycle push.
  always_comb begin
    if (flush_i) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
    end
  end

`ifdef BP_UPD_STATS_EN
  logic [15:0]     upd_cnt_q, upd_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0] q_count;
  logic [31:0]     drop_sum;

  assign q_count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    upd_cnt_d  = upd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = 32'(drop_cnt_q) + 32'(q_count);
    if (state_q == StWrite && upd_cnt_q != 16'hFFFF) upd_cnt_d = upd_cnt_q + 16'd1;
    if (flush_i) drop_cnt_d = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
  end

  assign upd_count_o  = upd_cnt_q;
  assign drop_count_o = drop_cnt_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rmw_idx_q   <= '0;
      rmw_data_q  <= '0;
      rmw_taken_q <= 1'b0;
`ifdef BP_UPD_STATS_EN
      upd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rmw_idx_q   <= rmw_idx_d;
      rmw_data_q  <= rmw_data_d;
      rmw_taken_q <= rmw_taken_d;
`ifdef BP_UPD_STATS_EN
      upd_cnt_q   <= upd_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  // Queue storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_idx_q[wr_addr]   <= upd_idx_i;
      q_taken_q[wr_addr] <= upd_taken_i;
    end
  end

  always_comb begin
    wr_en_raw   = 1'b0;
    wr_idx_raw  = '0;
    wr_data_raw = '0;
    unique case (state_q)
      StInit: begin
        wr_en_raw   = 1'b1;
        wr_idx_raw  = sweep_q;
        wr_data_raw = 2'b01;
      end
      StWrite: begin
        wr_en_raw   = 1'b1;
        wr_idx_raw  = rmw_idx_q;
        wr_data_raw = sat_update(rmw_data_q, rmw_taken_q);
      end
      default: ;
    endcase
  end

  // The reset state is INIT, whose decode asserts a write; gate the write port
  // and handshake with rst_ni so they are quiet for as long as reset is held.
  assign arr_wr_en_o   = rst_ni & wr_en_raw;
  assign arr_wr_idx_o  = rst_ni ? wr_idx_raw : '0;
  assign arr_wr_data_o = rst_ni ? wr_data_raw : 2'b00;
  assign upd_ready_o   = rst_ni & ~full;
  assign arr_rd_idx_o  = empty ? '0 : head_idx;
  assign init_busy_o   = (state_q == StInit);
  assign q_empty_o     = empty & (state_q != StWrite);

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl. An array model stores what the DUT
// writes; the reference is a FIFO of accepted updates plus the expected
// counter values, advanced with plain saturating arithmetic.
module tb_bp_update_ctrl;
  localparam int IB = 5;
  localparam int QD = 4;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_valid = 1'b0;
  logic [IB-1:0] upd_idx = '0;
  logic          upd_taken = 1'b0;
  logic          flush = 1'b0;
  logic          upd_ready;
  logic [IB-1:0] arr_rd_idx;
  logic [1:0]    arr_rd_data;
  logic          arr_wr_en;
  logic [IB-1:0] arr_wr_idx;
  logic [1:0]    arr_wr_data;
  logic          init_busy;
  logic          q_empty;
`ifdef BP_UPD_STATS_EN
  logic [15:0]   upd_count;
  logic [7:0]    drop_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [1:0]  mem [N];
  int          exp_arr [N];
  logic [IB:0] mq [$];
  int          exp_upd = 0;
  int          exp_drop = 0;

  bp_update_ctrl #(.INDEX_BITS(IB), .QUEUE_DEPTH(QD)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .upd_valid_i  (upd_valid),
    .upd_idx_i    (upd_idx),
    .upd_taken_i  (upd_taken),
    .upd_ready_o  (upd_ready),
    .flush_i      (flush),
    .arr_rd_idx_o (arr_rd_idx),
    .arr_rd_data_i(arr_rd_data),
    .arr_wr_en_o  (arr_wr_en),
    .arr_wr_idx_o (arr_wr_idx),
    .arr_wr_data_o(arr_wr_data),
    .init_busy_o  (init_busy),
    .q_empty_o    (q_empty)
`ifdef BP_UPD_STATS_EN
    ,
    .upd_count_o  (upd_count),
    .drop_count_o (drop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (arr_wr_en) mem[arr_wr_idx] <= arr_wr_data;
  assign arr_rd_data = mem[arr_rd_idx];

  function automatic int model_next(input int v, input bit taken);
    if (taken) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_upd  = 0;
    exp_drop = 0;
    for (int i = 0; i < N; i++) exp_arr[i] = 1;
  endfunction

  function automatic void model_pop(output bit have, output logic [IB-1:0] eidx,
                                    output logic [1:0] edata);
    logic [IB:0] e;
    have  = 1'b0;
    eidx  = '0;
    edata = '0;
    if (mq.size() != 0) begin
      e = mq.pop_front();
      have = 1'b1;
      eidx = e[IB-1:0];
      exp_arr[eidx] = model_next(exp_arr[eidx], e[IB]);
      edata = 2'(exp_arr[eidx]);
      exp_upd++;
    end
  endfunction

  function automatic void model_drive(input bit v, input logic [IB-1:0] i, input bit t,
                                      input bit f);
    if (f) begin
      exp_drop += mq.size();
      mq.delete();
    end else if (v && mq.size() < QD) begin
      mq.push_back({t, i});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit f, input int lo);
    upd_valid = v;
    flush     = f;
    upd_idx   = IB'($urandom_range(lo, N - 1));
    upd_taken = 1'($urandom);
    model_drive(v, upd_idx, upd_taken, f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upd_valid = 1'b1;
    flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (arr_wr_en !== 1'b0) begin
      failures++; $display("FAIL reset_wr_en: got %0b want 0", arr_wr_en);
    end
    checks++;
    if (init_busy !== 1'b1) begin
      failures++; $display("FAIL reset_init_busy: got %0b want 1", init_busy);
    end
    checks++;
    if (upd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_upd_ready: got %0b want 0", upd_ready);
    end
    checks++;
    if (q_empty !== 1'b1) begin
      failures++; $display("FAIL reset_q_empty: got %0b want 1", q_empty);
    end
    checks++;
    if (arr_rd_idx !== '0 || arr_wr_idx !== '0 || arr_wr_data !== 2'b00) begin
      failures++;
      $display("FAIL reset_indices: rd=%0d wr=%0d data=%0d want 0 0 0",
               arr_rd_idx, arr_wr_idx, arr_wr_data);
    end
`ifdef BP_UPD_STATS_EN
    checks++;
    if (upd_count !== 16'd0 || drop_count !== 8'd0) begin
      failures++; $display("FAIL reset_stats: upd=%0d drop=%0d want 0 0", upd_count, drop_count);
    end
`endif
    upd_valid = 1'b0;
  endtask

  // Sweep after reset release while six back-to-back updates try to queue.
  task automatic test_init_fill();
    int accepts = 0;
    int first_wr = -1;
    int last_wr = -1;
    int gap_bad = 0;
    int n_wr = 0;
    int bad = 0;
    bit have;
    logic [IB-1:0] eidx;
    logic [1:0] edata;
    bit qe [64];
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 50; c++) begin
      qe[c] = q_empty;
      if (c < N) begin
        checks++;
        if (init_busy !== 1'b1 || arr_wr_en !== 1'b1 || arr_wr_idx !== IB'(c) ||
            arr_wr_data !== 2'b01) begin
          failures++;
          $display("FAIL init_sweep: cycle %0d busy=%0b en=%0b idx=%0d data=%0d want 1 1 %0d 1",
                   c, init_busy, arr_wr_en, arr_wr_idx, arr_wr_data, c);
        end
      end else begin
        if (c == N) begin
          checks++;
          if (init_busy !== 1'b0 || arr_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL init_end: busy=%0b en=%0b want 0 0", init_busy, arr_wr_en);
          end
          bad = 0;
          for (int i = 0; i < N; i++) if (mem[i] !== 2'b01) bad++;
          checks++;
          if (bad != 0) begin
            failures++; $display("FAIL init_array: %0d entries not 01, want 0", bad);
          end
        end
        if (arr_wr_en) begin
          model_pop(have, eidx, edata);
          checks++;
          if (!have || arr_wr_idx !== eidx || arr_wr_data !== edata) begin
            failures++;
            $display("FAIL fill_write: idx=%0d data=%0d want idx=%0d data=%0d pending=%0b",
                     arr_wr_idx, arr_wr_data, eidx, edata, have);
          end
          if (first_wr < 0) first_wr = c;
          else if (c - last_wr != 2) gap_bad++;
          last_wr = c;
          n_wr++;
        end
      end
      checks++;
      if (upd_ready !== (mq.size() < QD)) begin
        failures++;
        $display("FAIL fill_ready: cycle %0d got %0b want %0b", c, upd_ready, mq.size() < QD);
      end
      if (c < 6 && upd_ready === 1'b1) accepts++;
      drive(c < 6, 1'b0, 8);
      tick();
    end
    checks++;
    if (accepts != QD) begin
      failures++; $display("FAIL fill_accepts: got %0d want %0d", accepts, QD);
    end
    checks++;
    if (n_wr != QD || first_wr != N + 1 || gap_bad != 0) begin
      failures++;
      $display("FAIL fill_drain: writes=%0d first=%0d bad_gaps=%0d want %0d %0d 0",
               n_wr, first_wr, gap_bad, QD, N + 1);
    end
    checks++;
    if (last_wr < 0 || qe[last_wr] !== 1'b0 || qe[last_wr + 1] !== 1'b1) begin
      failures++; $display("FAIL fill_q_empty: last write cycle %0d, q_empty not 0 then 1", last_wr);
    end
  endtask

  // Saturation at both ends, one isolated update at a time.
  task automatic test_saturation();
    int t_idx [8];
    int t_tk  [8];
    int t_exp [8];
    bit have;
    logic [IB-1:0] eidx;
    logic [1:0] edata;
    t_idx = '{7, 7, 7, 3, 3, 3, 3, 3};
    t_tk  = '{1, 1, 1, 0, 0, 1, 1, 1};
    t_exp = '{2, 3, 3, 0, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++) begin
      int lat = -1;
      int nwr = 0;
      upd_valid = 1'b1;
      flush     = 1'b0;
      upd_idx   = IB'(t_idx[k]);
      upd_taken = t_tk[k][0];
      model_drive(1'b1, upd_idx, upd_taken, 1'b0);
      tick();
      upd_valid = 1'b0;
      for (int w = 1; w <= 6; w++) begin
        if (arr_wr_en) begin
          nwr++;
          lat = w;
          model_pop(have, eidx, edata);
          checks++;
          if (arr_wr_idx !== IB'(t_idx[k]) || arr_wr_data !== 2'(t_exp[k])) begin
            failures++;
            $display("FAIL sat_write %0d: idx=%0d data=%0d want idx=%0d data=%0d",
                     k, arr_wr_idx, arr_wr_data, t_idx[k], t_exp[k]);
          end
        end
        if (w == 3) begin
          checks++;
          if (q_empty !== 1'b1) begin
            failures++; $display("FAIL sat_q_empty %0d: got %0b want 1", k, q_empty);
          end
        end
        tick();
      end
      checks++;
      if (lat != 2 || nwr != 1) begin
        failures++; $display("FAIL sat_latency %0d: write at %0d count %0d want 2 1", k, lat, nwr);
      end
    end
  endtask

  // Flush while a write is in flight with two more entries queued behind it.
  task automatic test_flush();
    int found = -1;
    int after_wr = 0;
    bit have;
    logic [IB-1:0] eidx;
    logic [1:0] edata;
    for (int c = 0; c < 20 && found < 0; c++) begin
      if (arr_wr_en) begin
        model_pop(have, eidx, edata);
        checks++;
        if (!have || arr_wr_idx !== eidx || arr_wr_data !== edata) begin
          failures++;
          $display("FAIL flush_write: idx=%0d data=%0d want idx=%0d data=%0d",
                   arr_wr_idx, arr_wr_data, eidx, edata);
        end
        if (mq.size() >= 2) found = c;
      end
      drive(1'b1, found >= 0, 0);
      tick();
    end
    checks++;
    if (found < 0) begin
      failures++; $display("FAIL flush_setup: no write with 2 queued behind it, got -1 want >=0");
    end
    checks++;
    if (q_empty !== 1'b1 || arr_wr_en !== 1'b0) begin
      failures++; $display("FAIL flush_empty: q_empty=%0b en=%0b want 1 0", q_empty, arr_wr_en);
    end
    drive(1'b0, 1'b0, 0);
    for (int c = 0; c < 8; c++) begin
      if (arr_wr_en) after_wr++;
      tick();
    end
    checks++;
    if (after_wr != 0) begin
      failures++; $display("FAIL flush_no_write: got %0d writes want 0", after_wr);
    end
`ifdef BP_UPD_STATS_EN
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      failures++; $display("FAIL flush_drop_count: got %0d want %0d", drop_count, exp_drop);
    end
`endif
  endtask

  task automatic test_random();
    int bad = 0;
    bit have;
    logic [IB-1:0] eidx;
    logic [1:0] edata;
    for (int c = 0; c < 316; c++) begin
      if (arr_wr_en) begin
        model_pop(have, eidx, edata);
        checks++;
        if (!have || arr_wr_idx !== eidx || arr_wr_data !== edata) begin
          failures++;
          $display("FAIL rand_write: cycle %0d idx=%0d data=%0d want idx=%0d data=%0d",
                   c, arr_wr_idx, arr_wr_data, eidx, edata);
        end
      end
      checks++;
      if (upd_ready !== (mq.size() < QD)) begin
        failures++;
        $display("FAIL rand_ready: cycle %0d got %0b want %0b", c, upd_ready, mq.size() < QD);
      end
      if (c < 300) drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 0);
      else drive(1'b0, 1'b0, 0);
      tick();
    end
    checks++;
    if (mq.size() != 0 || q_empty !== 1'b1) begin
      failures++; $display("FAIL rand_drain: pending=%0d q_empty=%0b want 0 1", mq.size(), q_empty);
    end
    for (int i = 0; i < N; i++) if (mem[i] !== 2'(exp_arr[i])) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rand_array: %0d counters differ, want 0", bad);
    end
`ifdef BP_UPD_STATS_EN
    checks++;
    if (upd_count !== 16'(exp_upd) || drop_count !== 8'(exp_drop)) begin
      failures++;
      $display("FAIL rand_stats: upd=%0d drop=%0d want %0d %0d",
               upd_count, drop_count, exp_upd, exp_drop);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    int extra = 0;
    int qbad = 0;
    drive(1'b1, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 0);
    for (int c = 0; c < 6 && !seen; c++) begin
      if (arr_wr_en) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rst_setup: no write seen, got 0 want 1");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (arr_wr_en !== 1'b0 || init_busy !== 1'b1 || upd_ready !== 1'b0 || q_empty !== 1'b1) begin
      failures++;
      $display("FAIL rst_abort: en=%0b busy=%0b ready=%0b q_empty=%0b want 0 1 0 1",
               arr_wr_en, init_busy, upd_ready, q_empty);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < N + 10; c++) begin
      if (c < N) begin
        checks++;
        if (arr_wr_en !== 1'b1 || arr_wr_idx !== IB'(c) || arr_wr_data !== 2'b01) begin
          failures++;
          $display("FAIL rst_sweep: cycle %0d en=%0b idx=%0d data=%0d want 1 %0d 1",
                   c, arr_wr_en, arr_wr_idx, arr_wr_data, c);
        end
      end else begin
        if (arr_wr_en) extra++;
        if (q_empty !== 1'b1) qbad++;
      end
      tick();
    end
    checks++;
    if (extra != 0 || qbad != 0) begin
      failures++; $display("FAIL rst_queue_empty: writes=%0d not_empty=%0d want 0 0", extra, qbad);
    end
`ifdef BP_UPD_STATS_EN
    checks++;
    if (upd_count !== 16'd0 || drop_count !== 8'd0) begin
      failures++; $display("FAIL rst_stats: upd=%0d drop=%0d want 0 0", upd_count, drop_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_saturation();
    test_flush();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
Sequencing controller for the gshare-style 2-bit counter array in the branch predictor. It sweeps every counter to weakly-not-taken after reset. It then serialises resolved-branch updates from writeback through a small queue. Each update is a two-cycle read-modify-write on the array's second read port and write port, which removes write-port contention from the WB stage.

Parameters:
INDEX_BITS, 5, counter-array index width; the array has 2^INDEX_BITS entries
QUEUE_DEPTH, 4, update-queue entries; must be a power of 2 and at least 2

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
upd_valid  input  1  WB presents a resolved conditional branch
upd_idx  input  INDEX_BITS  hashed counter index, already XORed with history by the caller
upd_taken  input  1  resolved direction
upd_ready  output  1  queue can accept; transfer occurs when upd_valid and upd_ready are both high
flush  input  1  discard pending updates
arr_rd_idx  output  INDEX_BITS  counter-array read-port-2 index
arr_rd_data  input  2  combinational read data for arr_rd_idx
arr_wr_en  output  1  counter-array write enable
arr_wr_idx  output  INDEX_BITS  write index
arr_wr_data  output  2  write data
init_busy  output  1  high while the initialisation sweep runs
q_empty  output  1  queue empty and no RMW in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low.
- While reset is low:
  - state=INIT, sweep counter=0, queue cleared.
  - arr_wr_en forced 0, init_busy=1, upd_ready=0, q_empty=1.
  - arr_rd_idx, arr_wr_idx and arr_wr_data are 0.
- States: INIT, IDLE, WRITE.
- INIT:
  - arr_wr_en=1, arr_wr_idx=sweep, arr_wr_data=2'b01; sweep increments each cycle.
  - After the cycle with sweep = 2^INDEX_BITS-1, go to IDLE. INIT lasts exactly 2^INDEX_BITS cycles.
  - init_busy=1 throughout. upd_ready is 1 if the queue is not full, so updates may queue during INIT. flush is honoured; the sweep is not affected.
- IDLE:
  - arr_wr_en=0 and arr_rd_idx=head.idx.
  - If the queue is non-empty and flush=0: at the edge, latch arr_rd_data, head.idx and head.taken into the RMW register, pop the head, go to WRITE.
  - If the queue is empty: arr_rd_idx=0 and the state stays IDLE.
- WRITE:
  - arr_wr_en=1 and arr_wr_idx=latched idx.
  - arr_wr_data is the saturating counter update of the latched data: if taken, 00->01, 01->10, 10->11, 11->11; if not taken, 00->00, 01->00, 10->01, 11->10.
  - Next state is always IDLE. Throughput is one update per 2 cycles. There is no read-after-write hazard because the next read occurs after the write commits.
- Latency: for an update accepted at edge e0 into an empty queue in IDLE, arr_wr_en is high in the cycle after edge e1 and the write commits at e2.
- Queue:
  - Circular FIFO with ptr width log2(QUEUE_DEPTH)+1 and wrap-around on pointers.
  - upd_ready = !full. Push and pop in the same cycle are allowed when not full; when full, upd_ready=0 and the pop frees a slot for the following cycle.
- flush:
  - At the edge, empties the queue and drops any same-cycle push.
  - Flush in IDLE suppresses the pop and RMW.
  - Flush in WRITE does not cancel the write in progress.
- q_empty = queue empty and state != WRITE.
- Reset asserted mid-RMW or mid-sweep aborts immediately. arr_wr_en drops asynchronously and the sweep restarts from index 0.

Optional Feature:
BP_UPD_STATS_EN: when defined, adds two outputs:
- upd_count[15:0]: number of WRITE-state writes since reset. Saturates at 16'hFFFF; INIT writes are not counted.
- drop_count[7:0]: number of queue entries discarded by flush. Saturates at 8'hFF.
Both counters reset to 0. When BP_UPD_STATS_EN is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with INDEX_BITS=5 -> arr_wr_en high for exactly 32 cycles, arr_wr_idx 0..31, data 2'b01, init_busy falls with the IDLE transition; array model reads 01 everywhere.
- After init, array[7]=01; push idx=7 taken=1 -> arr_wr_en high two cycles after accept, writes 10. Push again taken=1 -> 11. Push taken=1 -> remains 11.
- array[3]=00; push idx=3 taken=0 -> writes 00 (no underflow). Then taken=1 x3 -> 01, 10, 11.
- Hold upd_valid=1 for 6 cycles during INIT with QUEUE_DEPTH=4 -> upd_ready drops after 4 accepts. After INIT, the 4 updates commit in FIFO order, one every 2 cycles, and q_empty rises after the last write.
- Queue 3 entries, assert flush in a WRITE cycle -> the current write commits, the remaining entries never write, q_empty=1 next IDLE. With BP_UPD_STATS_EN: drop_count=2.
- Pull reset low mid-WRITE -> arr_wr_en=0 immediately. On release, a full 32-cycle sweep occurs and the queue is empty.
